// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Contents:
//   lsu_state_e     - unit FSM states
//   lsu_err_e       - response error codes (value is driven on resp_err)
//   F3_*            - RISC-V funct3 codes for the memory access sizes
//   lsu_decode_err  - funct3 legality and alignment check (range is checked by the top)
//   lsu_store_be    - byte enables for a store of the given size and byte offset
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_FUNCT3   = 2'd2,
        ERR_RANGE    = 2'd3
    } lsu_err_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal funct3 outranks misalignment.
    function automatic lsu_err_e lsu_decode_err(input logic       is_store,
                                                input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic legal;
        if (is_store)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        if (!legal)
            return ERR_FUNCT3;
        if ((funct3[1:0] == 2'b01) && addr_lo[0])
            return ERR_MISALIGN;
        if ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00))
            return ERR_MISALIGN;
        return ERR_NONE;
    endfunction

    function automatic logic [3:0] lsu_store_be(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the pipeline and the load/store unit.
// Parameter: TAG_W - destination-register tag width.
// Signals:
//   req_valid/req_ready       - request handshake (pipeline -> unit)
//   req_is_store, req_funct3, req_addr, req_wdata, req_tag - request payload
//   resp_valid/resp_ready     - response handshake (unit -> writeback)
//   resp_tag, resp_data, resp_err                          - response payload
// Modports: slave = the load/store unit, master = the pipeline side.
interface load_store_unit_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_is_store;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_data;
    logic [1:0]       resp_err;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
        output req_ready,
        output resp_valid, resp_tag, resp_data, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  resp_valid, resp_tag, resp_data, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-lane selection and extension.
// Ports:
//   rdata   in  32  raw memory word
//   addr_lo in  2   byte offset within the word
//   funct3  in  3   load funct3 (bit 2 = unsigned, bits 1:0 = size)
//   data    out 32  extended load result
module lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3[1:0])
            2'b00:   data = {{24{~funct3[2] & lane_b[7]}}, lane_b};
            2'b01:   data = {{16{~funct3[2] & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the synchronous data-memory port.
// Accepts one request at a time, checks funct3/alignment/range, performs the
// memory access and returns an extended load result or a store ack.
// Parameters: DMEM_BYTES (memory size, addresses >= fault), TAG_W (tag width).
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   bus (load_store_unit_if.slave) - request/response handshakes
//   mem_addr/mem_wdata/mem_we/mem_re out - registered memory command
//   mem_rdata in                 - read data, valid the cycle after mem_re
//   perf_loads/perf_stores/perf_errors out - only when LSU_PERF_CNT_EN is defined
// Optional feature macro: LSU_PERF_CNT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 16384,
    parameter int TAG_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     bus,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_we,
    output logic                 mem_re,
    input  logic [31:0]          mem_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_loads,
    output logic [31:0]          perf_stores,
    output logic [31:0]          perf_errors
`endif
);
    lsu_state_e       state_q, state_d;

    logic             is_store_q, is_store_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;

    logic             resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [31:0]      resp_data_q, resp_data_d;
    lsu_err_e         resp_err_q, resp_err_d;

    lsu_err_e         req_err;
    logic [31:0]      load_data;

    lsu_load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    always_comb begin
        req_err = lsu_decode_err(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0]);
        if ((req_err == ERR_NONE) && (bus.req_addr >= 32'(DMEM_BYTES)))
            req_err = ERR_RANGE;
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        tag_d        = tag_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = '0;
        mem_re_d     = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    funct3_d   = bus.req_funct3;
                    addr_lo_d  = bus.req_addr[1:0];
                    tag_d      = bus.req_tag;
                    if (req_err != ERR_NONE) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = req_err;
                        resp_data_d  = '0;
                        resp_tag_d   = bus.req_tag;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_is_store) begin
                            mem_we_d = lsu_store_be(bus.req_funct3, bus.req_addr[1:0]);
                            case (bus.req_funct3[1:0])
                                2'b00:   mem_wdata_d = {4{bus.req_wdata[7:0]}};
                                2'b01:   mem_wdata_d = {2{bus.req_wdata[15:0]}};
                                default: mem_wdata_d = bus.req_wdata;
                            endcase
                        end else begin
                            mem_re_d = 1'b1;
                        end
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (is_store_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_NONE;
                    resp_data_d  = '0;
                    resp_tag_d   = tag_q;
                    state_d      = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                resp_valid_d = 1'b1;
                resp_err_d   = ERR_NONE;
                resp_data_d  = load_data;
                resp_tag_d   = tag_q;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            tag_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= '0;
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            tag_q        <= tag_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_tag   = resp_tag_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_errors_q;

    // A faulting access is counted only as an error, never as a load/store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_errors_q <= '0;
        end else if ((state_q == RESP) && resp_valid_q && bus.resp_ready) begin
            if (resp_err_q != ERR_NONE)
                perf_errors_q <= perf_errors_q + 32'd1;
            else if (is_store_q)
                perf_stores_q <= perf_stores_q + 32'd1;
            else
                perf_loads_q  <= perf_loads_q + 32'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_errors = perf_errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a byte-array
// reference model of memory and the request rules, and a compare process
// that checks every cycle a response is presented.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
    logic        mem_re;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errors;
`endif

    load_store_unit_if #(.TAG_W(5)) bus ();

    load_store_unit #(.DMEM_BYTES(16384), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errors (perf_errors)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous data memory with byte write enables, 1-cycle read latency.
    logic [31:0] dmem [0:4095];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= dmem[mem_addr[13:2]];
        for (int k = 0; k < 4; k++)
            if (mem_we[k]) dmem[mem_addr[13:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    end

    // Reference model state: byte-addressed memory image.
    logic [7:0] ref_mem [0:16383];

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;
    exp_t exp_q[$];

    int passed = 0;
    int total  = 0;

    logic [31:0] last_data, last_wdata;
    logic [3:0]  last_we;
    logic [1:0]  last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expected outcome of a request, derived from the access rules.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [1:0] err,
                         output logic [31:0] data, output logic [3:0] we,
                         output logic [31:0] wd, output int lat);
        bit legal;
        int size;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        if (!legal)                 err = 2'd2;
        else if (addr % size != 0)  err = 2'd1;
        else if (addr >= 32'd16384) err = 2'd3;
        else                        err = 2'd0;
        data = 0; we = 0; wd = 0;
        if (err == 0 && !st) begin
            for (int i = 0; i < size; i++) data |= 32'(ref_mem[addr + i]) << (8 * i);
            if (!f3[2] && size < 4 && data[8*size-1]) data |= 32'hFFFF_FFFF << (8 * size);
        end
        if (err == 0 && st) begin
            we = 4'(((1 << size) - 1) << (addr % 4));
            for (int k = 0; k < 4; k++) wd[8*k +: 8] = wdata[8*(k % size) +: 8];
        end
        lat = (err != 0) ? 1 : (st ? 2 : 3);
    endtask

    // Compare process: every cycle a response is shown it must match the model.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            if (exp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else begin
                chk("resp_tag",  32'(bus.resp_tag), 32'(exp_q[0].tag));
                chk("resp_data", bus.resp_data,     exp_q[0].data);
                chk("resp_err",  32'(bus.resp_err), 32'(exp_q[0].err));
            end
        end
    end
    always @(posedge clk)
        if (rst_n && bus.resp_valid && bus.resp_ready && exp_q.size() > 0) exp_q.pop_front();

    task automatic wait_ready();
        int waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_tag      = tag;
    endtask

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] tag, input int hold);
        logic [1:0]  e_err;
        logic [31:0] e_data, e_wd;
        logic [3:0]  e_we;
        int          e_lat;
        bit          seen = 0;
        model(st, f3, addr, wdata, e_err, e_data, e_we, e_wd, e_lat);
        bus.resp_ready = (hold == 0);
        wait_ready();
        drive(st, f3, addr, wdata, tag);
        exp_q.push_back('{tag: tag, data: e_data, err: e_err});
        if (st && e_err == 0)
            for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[addr + i] = wdata[8*i +: 8];
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        last_lat = 0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (n == 1) begin
                last_we    = mem_we;
                last_wdata = mem_wdata;
                chk("access_we", 32'(mem_we), 32'(e_we));
                chk("access_re", 32'(mem_re), 32'((e_err == 0) && !st));
                if (e_err == 0) chk("access_addr", mem_addr, {addr[31:2], 2'b00});
                if (e_err == 0 && st) chk("access_wdata", mem_wdata, e_wd);
            end else begin
                chk("idle_we", 32'(mem_we), 32'd0);
                chk("idle_re", 32'(mem_re), 32'd0);
            end
            if (bus.resp_valid) begin
                seen      = 1;
                last_lat  = n;
                last_data = bus.resp_data;
                last_err  = bus.resp_err;
            end
        end
        chk("resp_latency", 32'(last_lat), 32'(e_lat));
        if (!seen) begin
            bus.resp_ready = 1'b1;
            exp_q.delete();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", 32'(bus.resp_valid), 32'd0);
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic reset_during_store();
        wait_ready();
        drive(1'b1, 3'b010, 32'h200, 32'h1234_5678, 5'd20);
        exp_q.push_back('{tag: 5'd20, data: 32'd0, err: 2'd0});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rst_pre_we", 32'(mem_we), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(mem_we), 32'd0);
        chk("rst_async_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_async_req_ready", 32'(bus.req_ready), 32'd1);
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_post_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_post_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_post_we", 32'(mem_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b1;

        #12;
        chk("reset_mem_addr",   mem_addr,  32'd0);
        chk("reset_mem_wdata",  mem_wdata, 32'd0);
        chk("reset_mem_we",     32'(mem_we), 32'd0);
        chk("reset_mem_re",     32'(mem_re), 32'd0);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_resp_data",  bus.resp_data, 32'd0);
        chk("reset_resp_tag",   32'(bus.resp_tag), 32'd0);
        chk("reset_resp_err",   32'(bus.resp_err), 32'd0);
        chk("reset_req_ready",  32'(bus.req_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        run_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd1, 0);
        chk("sw_we", 32'(last_we), 32'hF);
        chk("sw_lat", 32'(last_lat), 32'd2);
        run_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd2, 0);
        chk("lw_data", last_data, 32'hDEAD_BEEF);
        chk("lw_lat", 32'(last_lat), 32'd3);

        run_req(1'b1, 3'b000, 32'h103, 32'h0000_0080, 5'd3, 0);
        chk("sb_we", 32'(last_we), 32'h8);
        chk("sb_wdata", last_wdata, 32'h8080_8080);
        run_req(1'b0, 3'b000, 32'h103, 32'd0, 5'd4, 0);
        chk("lb_data", last_data, 32'hFFFF_FF80);
        run_req(1'b0, 3'b100, 32'h103, 32'd0, 5'd5, 0);
        chk("lbu_data", last_data, 32'h0000_0080);

        run_req(1'b1, 3'b001, 32'h102, 32'h0000_8001, 5'd6, 0);
        chk("sh_we", 32'(last_we), 32'hC);
        chk("sh_wdata", last_wdata, 32'h8001_8001);
        run_req(1'b0, 3'b001, 32'h102, 32'd0, 5'd7, 0);
        chk("lh_data", last_data, 32'hFFFF_8001);
        run_req(1'b0, 3'b101, 32'h102, 32'd0, 5'd8, 0);
        chk("lhu_data", last_data, 32'h0000_8001);

        run_req(1'b0, 3'b010, 32'h101, 32'd0, 5'd9, 0);
        chk("err_misalign", 32'(last_err), 32'd1);
        chk("err_lat", 32'(last_lat), 32'd1);
        run_req(1'b0, 3'b011, 32'h100, 32'd0, 5'd10, 0);
        chk("err_funct3_load", 32'(last_err), 32'd2);
        run_req(1'b1, 3'b100, 32'h100, 32'h55, 5'd11, 0);
        chk("err_funct3_store", 32'(last_err), 32'd2);
        run_req(1'b0, 3'b010, 32'h4000, 32'd0, 5'd12, 0);
        chk("err_range", 32'(last_err), 32'd3);
        run_req(1'b0, 3'b001, 32'h4001, 32'd0, 5'd13, 0);
        chk("err_prio_misalign", 32'(last_err), 32'd1);
        run_req(1'b0, 3'b011, 32'h4001, 32'd0, 5'd14, 0);
        chk("err_prio_funct3", 32'(last_err), 32'd2);

        run_req(1'b0, 3'b010, 32'h100, 32'd0, 5'd15, 5);
        chk("stall_lw_data", last_data, 32'h8001_BEEF);

        run_req(1'b1, 3'b000, 32'h3FFF, 32'h0000_005A, 5'd16, 0);
        run_req(1'b0, 3'b100, 32'h3FFF, 32'd0, 5'd17, 0);
        chk("top_byte_data", last_data, 32'h0000_005A);

        run_req(1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 5'd18, 0);
        reset_during_store();
        run_req(1'b0, 3'b010, 32'h200, 32'd0, 5'd19, 0);
        chk("rst_word_kept", last_data, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
